// File: rtl/div.sv
// 32-bit restoring divider for the EX stage. Handles signed (DIV) and unsigned
// (DIVU) operations, producing {remainder, quotient} after 32 iterations, or
// a zero result two edges after acceptance on a zero divisor.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    // {partial remainder, dividend/quotient}; bit 0 receives each new quotient bit
    logic [64:0] dividend_q;
    logic [31:0] divisor_q;
    logic        quo_neg_q;
    logic        rem_neg_q;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] div_temp;
    logic [64:0] dividend_step;
    logic [31:0] quo_raw;
    logic [31:0] rem_raw;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    // Operand magnitudes, one restoring step and the final sign fixup
    always_comb begin
        a_neg = signed_div_i & opdata1_i[31];
        b_neg = signed_div_i & opdata2_i[31];
        abs_a = a_neg ? (~opdata1_i + 32'd1) : opdata1_i;
        abs_b = b_neg ? (~opdata2_i + 32'd1) : opdata2_i;

        // Borrow out (bit 32) means the trial subtraction failed: keep remainder
        div_temp = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
        if (div_temp[32]) begin
            dividend_step = {dividend_q[63:0], 1'b0};
        end else begin
            dividend_step = {div_temp[31:0], dividend_q[31:0], 1'b1};
        end

        quo_raw = dividend_step[31:0];
        rem_raw = dividend_step[64:33];
        // -2^31 / -1 falls out naturally: magnitude 0x80000000 is not negated
        quo_fix = quo_neg_q ? (~quo_raw + 32'd1) : quo_raw;
        rem_fix = rem_neg_q ? (~rem_raw + 32'd1) : rem_raw;
    end

    // Control FSM with registered result and ready
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StFree;
            cnt_q      <= 6'd0;
            dividend_q <= 65'd0;
            divisor_q  <= 32'd0;
            quo_neg_q  <= 1'b0;
            rem_neg_q  <= 1'b0;
            result_o   <= 64'd0;
            ready_o    <= 1'b0;
        end else begin
            case (state_q)
                StFree: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state_q <= StByZero;
                        end else begin
                            state_q    <= StOn;
                            cnt_q      <= 6'd0;
                            dividend_q <= {32'd0, abs_a, 1'b0};
                            divisor_q  <= abs_b;
                            quo_neg_q  <= a_neg ^ b_neg;
                            rem_neg_q  <= a_neg;
                        end
                    end
                end
                StByZero: begin
                    result_o <= 64'd0;
                    if (annul_i) begin
                        state_q <= StFree;
                        ready_o <= 1'b0;
                    end else begin
                        state_q <= StEnd;
                        ready_o <= 1'b1;
                    end
                end
                StOn: begin
                    if (annul_i) begin
                        state_q  <= StFree;
                        cnt_q    <= 6'd0;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end else begin
                        dividend_q <= dividend_step;
                        cnt_q      <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            result_o <= {rem_fix, quo_fix};
                            ready_o  <= 1'b1;
                            state_q  <= StEnd;
                        end
                    end
                end
                StEnd: begin
                    if (!start_i) begin
                        state_q  <= StFree;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end
                end
                default: begin
                    state_q  <= StFree;
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                end
            endcase
        end
    end

endmodule
